ec1_datapath: RTL and testbench

EC-1 datapath. Holds program memory, program counter (PC), instruction register (IR), accumulator (A) and output register. It executes the one-cycle strobes issued by the EC-1 control unit and returns two things to it: the opcode field IR[7:5] and the A-nonzero flag. It sits directly downstream of the control unit and is the only block that touches program or I/O data.

---
 rtl/ec1_datapath.sv | 96 +++++++++
 tb/tb_ec1_datapath.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ec1_datapath.sv
`default_nettype none
// ============================================================================
// Module   : ec1_datapath
// Brief    : EC-1 datapath - program memory, PC, IR, accumulator, output port.
// Revision : 1.0
// ============================================================================
module ec1_datapath #(
   parameter int    DW        = 8,
   parameter string INIT_FILE = ""
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          IRload,
   input  logic          PCload,
   input  logic          INmux,
   input  logic          Aload,
   input  logic          JNZmux,
   input  logic          OutE,
   input  logic          Halt1,
   input  logic [DW-1:0] data_in,
   input  logic          prog_we,
   input  logic [4:0]    prog_addr,
   input  logic [7:0]    prog_wdata,
   output logic [2:0]    IR_op,
   output logic          A_nz,
   output logic [4:0]    pc,
   output logic [DW-1:0] data_out,
   output logic          out_valid,
   output logic          halted
);

   localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

   logic [7:0]    r_mem [0:31];
   logic [7:0]    r_ir;
   logic [4:0]    r_pc;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_dout;
   logic          r_out_valid;
   logic          r_halted;

   logic [7:0]    w_fetch_word;
   logic [4:0]    w_pc_next;
   logic [DW-1:0] w_a_next;

   generate
      begin : g_init_zero
         initial begin
            for (int i = 0; i < 32; i++) r_mem[i] = 8'h00;
         end
      end
   endgenerate

   // Program memory is untouched by reset and stays writable while halted.
   always_ff @(posedge clk) begin
      if (prog_we) r_mem[prog_addr] <= prog_wdata;
   end

   assign w_fetch_word = r_mem[r_pc];
   assign w_pc_next    = JNZmux ? r_ir[4:0] : r_pc + 5'd1;
   assign w_a_next     = INmux ? data_in : r_a - c_one;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir        <= 8'h00;
         r_pc        <= 5'd0;
         r_a         <= '0;
         r_dout      <= '0;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (Halt1) r_halted <= 1'b1;
         // All register loads sample pre-edge values, so fetch and
         // Aload+OutE combinations see the old PC / old A.
         if (!r_halted) begin
            if (IRload) r_ir <= w_fetch_word;
            if (PCload) r_pc <= w_pc_next;
            if (Aload)  r_a  <= w_a_next;
            if (OutE) begin
               r_dout      <= r_a;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   assign IR_op     = r_ir[7:5];
   assign A_nz      = |r_a;
   assign pc        = r_pc;
   assign data_out  = r_dout;
   assign out_valid = r_out_valid;
   assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ec1_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_ec1_datapath
// Brief    : Directed + randomized bench for ec1_datapath against a reference model.
// Revision : 1.0
// ============================================================================
module tb_ec1_datapath;

   localparam int DW   = 8;
   localparam int MASK = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          IRload = 0, PCload = 0, INmux = 0, Aload = 0, JNZmux = 0, OutE = 0, Halt1 = 0;
   logic [DW-1:0] data_in = '0;
   logic          prog_we = 0;
   logic [4:0]    prog_addr = '0;
   logic [7:0]    prog_wdata = '0;
   logic [2:0]    IR_op;
   logic          A_nz;
   logic [4:0]    pc;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic          halted;

   ec1_datapath #(.DW(DW), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .IRload(IRload), .PCload(PCload), .INmux(INmux),
      .Aload(Aload), .JNZmux(JNZmux), .OutE(OutE), .Halt1(Halt1), .data_in(data_in),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .IR_op(IR_op), .A_nz(A_nz), .pc(pc), .data_out(data_out),
      .out_valid(out_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: whole-machine state as plain integers.
   int m_mem [32];
   int m_ir, m_pc, m_a, m_out;
   bit m_ov, m_halt;

   initial for (int i = 0; i < 32; i++) m_mem[i] = 0;

   always @(posedge clk or posedge reset) begin : model
      int nir, npc, na, nout;
      bit nov;
      if (reset) begin
         m_ir = 0; m_pc = 0; m_a = 0; m_out = 0; m_ov = 0; m_halt = 0;
      end else begin
         nir = m_ir; npc = m_pc; na = m_a; nout = m_out; nov = 0;
         if (!m_halt) begin
            if (IRload) nir = m_mem[m_pc];
            if (PCload) npc = JNZmux ? (m_ir % 32) : (m_pc + 1) % 32;
            if (Aload)  na  = INmux ? int'(data_in) : (m_a + MASK) & MASK;
            if (OutE) begin
               nout = m_a;
               nov  = 1;
            end
         end
         if (Halt1) m_halt = 1;
         if (prog_we) m_mem[prog_addr] = prog_wdata;
         m_ir = nir; m_pc = npc; m_a = na; m_out = nout; m_ov = nov;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pc",        32'(pc),        32'(m_pc));
         check("IR_op",     32'(IR_op),     32'(m_ir / 32));
         check("A_nz",      32'(A_nz),      32'(m_a != 0));
         check("data_out",  32'(data_out),  32'(m_out));
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("halted",    32'(halted),    32'(m_halt));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic strobe(input logic irl, pcl, inm, al, jm, oe, h);
      IRload = irl; PCload = pcl; INmux = inm; Aload = al; JNZmux = jm; OutE = oe; Halt1 = h;
      tick();
      IRload = 0; PCload = 0; INmux = 0; Aload = 0; JNZmux = 0; OutE = 0; Halt1 = 0;
   endtask

   task automatic pwrite(input logic [4:0] addr, input logic [7:0] data);
      prog_we = 1; prog_addr = addr; prog_wdata = data;
      tick();
      prog_we = 0;
   endtask

   task automatic sync_reset();
      reset = 1;
      tick();
      reset = 0;
   endtask

   logic [7:0] prog [5] = '{8'h60, 8'h80, 8'hA0, 8'hC1, 8'hE0};
   int outs[$];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int op, guard;
      tick();
      tick();
      check("rst_pc",     32'(pc), 0);
      check("rst_IR_op",  32'(IR_op), 0);
      check("rst_dout",   32'(data_out), 0);
      check("rst_ovalid", 32'(out_valid), 0);
      check("rst_halted", 32'(halted), 0);
      reset = 0;
      chk_en = 1;

      for (int i = 0; i < 5; i++) pwrite(5'(i), prog[i]);
      pwrite(5'd31, 8'hA0);

      // Reset landing mid-cycle must clear outputs before the next edge.
      strobe(1, 1, 0, 0, 0, 0, 0);
      strobe(1, 1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2 reset = 1;
      #1;
      check("midrst_pc",    32'(pc), 0);
      check("midrst_IR_op", 32'(IR_op), 0);
      check("midrst_A_nz",  32'(A_nz), 0);
      tick();
      reset = 0;
      strobe(1, 1, 0, 0, 0, 0, 0);
      check("post_rst_IR_op", 32'(IR_op), 3'b011);
      check("post_rst_pc",    32'(pc), 1);

      for (int i = 0; i < 30; i++) strobe(0, 1, 0, 0, 0, 0, 0);
      check("pc_at_31", 32'(pc), 31);
      strobe(1, 1, 0, 0, 0, 0, 0);
      check("wrap_IR_op", 32'(IR_op), 3'b101);
      check("wrap_pc",    32'(pc), 0);

      data_in = 8'h03;
      strobe(0, 0, 1, 1, 0, 0, 0);
      check("acc_load_nz", 32'(A_nz), 1);
      repeat (3) strobe(0, 0, 0, 1, 0, 0, 0);
      check("acc_zero_nz", 32'(A_nz), 0);
      strobe(0, 0, 0, 1, 0, 0, 0);
      check("acc_under_nz", 32'(A_nz), 1);
      strobe(0, 0, 0, 0, 0, 1, 0);
      check("acc_under_val", 32'(data_out), 32'hFF);

      repeat (3) strobe(0, 1, 0, 0, 0, 0, 0);
      strobe(1, 0, 0, 0, 0, 0, 0);
      check("jnz_IR_op", 32'(IR_op), 3'b110);
      strobe(0, 1, 0, 0, 1, 0, 0);
      check("jnz_pc", 32'(pc), 1);
      data_in = 8'h05;
      strobe(0, 0, 1, 1, 0, 0, 0);
      strobe(0, 0, 0, 1, 0, 1, 0);
      check("aout_dout",  32'(data_out), 5);
      check("aout_valid", 32'(out_valid), 1);
      tick();
      check("aout_pulse", 32'(out_valid), 0);
      strobe(0, 0, 0, 0, 0, 1, 0);
      check("aout_newA", 32'(data_out), 4);

      strobe(0, 0, 0, 0, 0, 0, 1);
      check("halt_set", 32'(halted), 1);
      data_in = 8'h09;
      strobe(1, 0, 0, 0, 0, 0, 0);
      strobe(0, 1, 0, 0, 0, 0, 0);
      strobe(0, 0, 1, 1, 0, 0, 0);
      strobe(0, 0, 0, 0, 0, 1, 0);
      pwrite(5'd5, 8'h77);
      check("halt_pc",    32'(pc), 1);
      check("halt_IR_op", 32'(IR_op), 3'b110);
      check("halt_dout",  32'(data_out), 4);
      check("halt_ov",    32'(out_valid), 0);
      check("halt_A_nz",  32'(A_nz), 1);
      sync_reset();
      check("halt_clear", 32'(halted), 0);
      repeat (5) strobe(0, 1, 0, 0, 0, 0, 0);
      strobe(1, 0, 0, 0, 0, 0, 0);
      check("halt_prog_we", 32'(IR_op), 3'b011);

      // Control-unit style run of the countdown program.
      sync_reset();
      data_in = 8'h03;
      guard = 0;
      while (!m_halt && guard < 40) begin
         strobe(1, 1, 0, 0, 0, 0, 0);
         strobe(0, 0, 0, 0, 0, 0, 0);
         op = m_ir / 32;
         case (op)
            3: strobe(0, 0, 1, 1, 0, 0, 0);
            4: begin
               strobe(0, 0, 0, 0, 0, 1, 0);
               if (out_valid) outs.push_back(int'(data_out));
            end
            5: strobe(0, 0, 0, 1, 0, 0, 0);
            6: strobe(0, m_a != 0, 0, 0, 1, 0, 0);
            7: strobe(0, 0, 0, 0, 0, 0, 1);
            default: strobe(0, 0, 0, 0, 0, 0, 0);
         endcase
         guard++;
      end
      check("prog_bound", 32'(guard < 40), 1);
      check("prog_nouts", 32'(outs.size()), 3);
      if (outs.size() == 3) begin
         check("prog_out0", 32'(outs[0]), 3);
         check("prog_out1", 32'(outs[1]), 2);
         check("prog_out2", 32'(outs[2]), 1);
      end
      check("prog_halted", 32'(halted), 1);
      check("prog_A_nz",   32'(A_nz), 0);
      check("prog_pc",     32'(pc), 5);

      sync_reset();
      for (int i = 0; i < 2000; i++) begin
         IRload  = 1'($urandom);
         PCload  = 1'($urandom);
         INmux   = 1'($urandom);
         Aload   = 1'($urandom);
         JNZmux  = 1'($urandom);
         OutE    = 1'($urandom);
         Halt1   = ($urandom_range(0, 199) == 0);
         data_in = DW'($urandom);
         prog_we = ($urandom_range(0, 3) == 0);
         prog_addr  = 5'($urandom);
         prog_wdata = 8'($urandom);
         reset   = ($urandom_range(0, 149) == 0);
         tick();
      end
      IRload = 0; PCload = 0; INmux = 0; Aload = 0; JNZmux = 0; OutE = 0; Halt1 = 0;
      prog_we = 0; reset = 0;
      tick();
      chk_en = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
